rc4_prga_decrypt: RTL and testbench

- Downstream stage of the RC4 key-scheduling FSM; starts when that FSM's done signal rises.
- Runs the RC4 pseudo-random generation over the already-scheduled S array in the shared 256x8 S RAM.
- XORs each keystream byte with one byte of the 32x8 encrypted-message ROM and writes the result to the 32x8 decrypted-message RAM.
- Also flags whether every decrypted byte is printable (lowercase a-z or space), so the top level can judge the key.

---
 rtl/rc4_prga_decrypt.sv | 206 ++++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 keystream generator that decrypts a 32-byte ROM message into RAM
// and flags whether the result is all lowercase letters and spaces.
module rc4_prga_decrypt #(
  parameter int MSG_LEN    = 32,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       master_reset,
  input  logic       start,
  output logic [7:0] s_address,
  output logic [7:0] s_data_out,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] enc_address,
  input  logic [7:0] enc_q,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data_out,
  output logic       dec_wren,
  output logic       done,
  output logic       key_valid
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, CAP_SI, RD_SJ, CAP_SJ, WR_I, WR_J,
    RD_F, CAP_F, WR_DEC, CHECK, FINISH
  } state_t;

  localparam logic [7:0] RW      = 8'(READ_WAIT);
  localparam logic [7:0] WW      = 8'(WRITE_WAIT);
  localparam logic [5:0] LAST_K  = 6'(MSG_LEN);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] i, j, si, sj, f;
  logic [5:0] k;
  logic [7:0] chk_byte;
  logic       chk_ok;
  logic       rd_done, wr_done;

  function automatic logic printable(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
  endfunction

  // enc_address is untouched between RD_F and CHECK, so enc_q is still this byte's ciphertext.
  assign chk_byte = f ^ enc_q;
  assign chk_ok   = printable(chk_byte);
  assign rd_done  = (wait_cnt == RW);
  assign wr_done  = (wait_cnt == WW);

  always_ff @(posedge clk or posedge master_reset) begin
    if (master_reset) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      i            <= 8'd0;
      j            <= 8'd0;
      si           <= 8'd0;
      sj           <= 8'd0;
      f            <= 8'd0;
      k            <= 6'd0;
      s_address    <= 8'd0;
      s_data_out   <= 8'd0;
      s_wren       <= 1'b0;
      enc_address  <= 5'd0;
      dec_address  <= 5'd0;
      dec_data_out <= 8'd0;
      dec_wren     <= 1'b0;
      done         <= 1'b0;
      key_valid    <= 1'b0;
    end else if (!start) begin
      // Losing start hands the S RAM back to the key scheduler, so release every output.
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      i            <= 8'd0;
      j            <= 8'd0;
      k            <= 6'd0;
      s_address    <= 8'd0;
      s_data_out   <= 8'd0;
      s_wren       <= 1'b0;
      enc_address  <= 5'd0;
      dec_address  <= 5'd0;
      dec_data_out <= 8'd0;
      dec_wren     <= 1'b0;
      done         <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i         <= 8'd0;
          j         <= 8'd0;
          k         <= 6'd0;
          wait_cnt  <= 8'd0;
          done      <= 1'b0;
          key_valid <= 1'b1;
          state     <= INC_I;
        end
        INC_I: begin
          i         <= i + 8'd1;
          s_address <= i + 8'd1;
          s_wren    <= 1'b0;
          wait_cnt  <= 8'd0;
          state     <= RD_SI;
        end
        RD_SI: begin
          if (rd_done) begin
            wait_cnt <= 8'd0;
            state    <= CAP_SI;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CAP_SI: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
          state     <= RD_SJ;
        end
        RD_SJ: begin
          if (rd_done) begin
            wait_cnt <= 8'd0;
            state    <= CAP_SJ;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CAP_SJ: begin
          sj         <= s_q;
          s_address  <= i;
          s_data_out <= s_q;
          s_wren     <= 1'b1;
          state      <= WR_I;
        end
        WR_I: begin
          if (wr_done) begin
            wait_cnt   <= 8'd0;
            s_address  <= j;
            s_data_out <= si;
            s_wren     <= 1'b1;
            state      <= WR_J;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WR_J: begin
          if (wr_done) begin
            // Reading s[si+sj] only after both writes gives the post-swap value when it aliases i or j.
            wait_cnt    <= 8'd0;
            s_wren      <= 1'b0;
            s_address   <= si + sj;
            enc_address <= k[4:0];
            state       <= RD_F;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_F: begin
          if (rd_done) begin
            wait_cnt <= 8'd0;
            state    <= CAP_F;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CAP_F: begin
          f            <= s_q;
          dec_address  <= k[4:0];
          dec_data_out <= s_q ^ enc_q;
          dec_wren     <= 1'b1;
          state        <= WR_DEC;
        end
        WR_DEC: begin
          if (wr_done) begin
            wait_cnt <= 8'd0;
            dec_wren <= 1'b0;
            state    <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CHECK: begin
          if (!chk_ok) key_valid <= 1'b0;
          if (!chk_ok && CHECK_EN) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            k <= k + 6'd1;
            if (k + 6'd1 == LAST_K) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= INC_I;
            end
          end
        end
        FINISH: begin
          done     <= 1'b1;
          s_wren   <= 1'b0;
          dec_wren <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - directed bench with S/ROM/RAM models and a reference RC4 keystream model.
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       start [2];
  logic [7:0] s_address [2];
  logic [7:0] s_data_out [2];
  logic       s_wren [2];
  logic [7:0] s_q [2];
  logic [4:0] enc_address [2];
  logic [7:0] enc_q [2];
  logic [4:0] dec_address [2];
  logic [7:0] dec_data_out [2];
  logic       dec_wren [2];
  logic       done [2];
  logic       key_valid [2];

  logic [7:0] s_mem [2][256];
  logic [7:0] enc_mem [2][32];
  logic [7:0] dec_mem [2][32];
  logic [7:0] s_init [256];
  logic       load [2];

  logic [7:0] ks [32];
  string      pt = "the quick brown fox jumps over a";

  logic       snap_arm;
  logic       snap_got;
  logic [7:0] snap2, snap3;

  int n_checks = 0;
  int n_pass   = 0;

  rc4_prga_decrypt #(.CHECK_EN(1'b1)) dut0 (
    .clk(clk), .master_reset(rst[0]), .start(start[0]),
    .s_address(s_address[0]), .s_data_out(s_data_out[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
    .enc_address(enc_address[0]), .enc_q(enc_q[0]),
    .dec_address(dec_address[0]), .dec_data_out(dec_data_out[0]), .dec_wren(dec_wren[0]),
    .done(done[0]), .key_valid(key_valid[0])
  );

  rc4_prga_decrypt #(.CHECK_EN(1'b0)) dut1 (
    .clk(clk), .master_reset(rst[1]), .start(start[1]),
    .s_address(s_address[1]), .s_data_out(s_data_out[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
    .enc_address(enc_address[1]), .enc_q(enc_q[1]),
    .dec_address(dec_address[1]), .dec_data_out(dec_data_out[1]), .dec_wren(dec_wren[1]),
    .done(done[1]), .key_valid(key_valid[1])
  );

  // Synchronous-read memories; load copies s_init into S and fills the decrypted RAM with 0xEE.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (load[u]) begin
        for (int a = 0; a < 256; a++) s_mem[u][a] <= s_init[a];
        for (int a = 0; a < 32; a++) dec_mem[u][a] <= 8'hee;
      end else begin
        if (s_wren[u]) s_mem[u][s_address[u]] <= s_data_out[u];
        if (dec_wren[u]) dec_mem[u][dec_address[u]] <= dec_data_out[u];
      end
      s_q[u]   <= s_mem[u][s_address[u]];
      enc_q[u] <= enc_mem[u][enc_address[u]];
    end
  end

  always @(posedge clk) begin
    if (snap_arm && dec_wren[0] && dec_address[0] == 5'd1) begin
      snap2    <= s_mem[0][2];
      snap3    <= s_mem[0][3];
      snap_got <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ident();
    for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
  endtask

  task automatic ksa(input logic [23:0] key);
    logic [7:0] jj, t;
    ident();
    jj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      jj = jj + s_init[a] + key[8*(2-(a%3)) +: 8];
      t = s_init[a]; s_init[a] = s_init[jj]; s_init[jj] = t;
    end
  endtask

  task automatic make_ks();
    logic [7:0] ms [256];
    logic [7:0] ii, jj, t, idx;
    for (int a = 0; a < 256; a++) ms[a] = s_init[a];
    ii = 8'd0; jj = 8'd0;
    for (int n = 0; n < 32; n++) begin
      ii = ii + 8'd1;
      jj = jj + ms[ii];
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
      idx = ms[ii] + ms[jj];
      ks[n] = ms[idx];
    end
  endtask

  task automatic load_mem(input int u);
    @(negedge clk); load[u] = 1'b1;
    @(negedge clk); load[u] = 1'b0;
  endtask

  task automatic run(input int u, input int limit, output int cyc);
    @(negedge clk); start[u] = 1'b1;
    cyc = 0;
    while (!done[u] && cyc < limit) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic stop(input int u);
    @(negedge clk); start[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, bad, seen;
    rst = '{1'b1, 1'b1};
    start = '{1'b0, 1'b0};
    load = '{1'b0, 1'b0};
    snap_arm = 1'b0;
    snap_got = 1'b0;
    for (int u = 0; u < 2; u++) for (int a = 0; a < 32; a++) enc_mem[u][a] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_done", done[0], 0);
    check("rst_key_valid", key_valid[0], 0);
    check("rst_s_wren", s_wren[0], 0);
    check("rst_dec_wren", dec_wren[0], 0);
    check("rst_s_address", s_address[0], 0);
    check("rst_enc_address", enc_address[0], 0);
    @(negedge clk); rst = '{1'b0, 1'b0};

    // Identity S, zero ciphertext, abort on the first byte.
    ident(); load_mem(0);
    run(0, 100, cyc);
    check("t1_cycles", cyc, 24);
    check("t1_dec0", dec_mem[0][0], 8'h02);
    check("t1_dec1", dec_mem[0][1], 8'hee);
    check("t1_dec31", dec_mem[0][31], 8'hee);
    check("t1_key_valid", key_valid[0], 0);
    check("t1_done", done[0], 1);
    check("t1_s_wren", s_wren[0], 0);
    check("t1_dec_wren", dec_wren[0], 0);
    stop(0);
    check("t1_done_drop", done[0], 0);

    // Same preload without abort: whole keystream lands in the decrypted RAM.
    ident(); make_ks(); load_mem(1);
    run(1, 900, cyc);
    check("t2_cycles", cyc, 737);
    check("t2_key_valid", key_valid[1], 0);
    for (int n = 0; n < 32; n++) check($sformatf("t2_dec%0d", n), dec_mem[1][n], ks[n]);
    stop(1);

    // Two printable bytes, third aborts; swap of byte 1 captured mid-run.
    ident();
    enc_mem[0][0] = 8'h63; enc_mem[0][1] = 8'h25;
    load_mem(0);
    snap_arm = 1'b1;
    run(0, 200, cyc);
    snap_arm = 1'b0;
    check("t3_cycles", cyc, 70);
    check("t3_dec0", dec_mem[0][0], 8'h61);
    check("t3_dec1", dec_mem[0][1], 8'h20);
    check("t3_dec2", dec_mem[0][2], 8'h07);
    check("t3_key_valid", key_valid[0], 0);
    check("t3_snap_got", snap_got, 1);
    check("t3_s2", snap2, 8'h03);
    check("t3_s3", snap3, 8'h02);
    stop(0);

    // Golden ciphertext from key 0x000249.
    ksa(24'h000249); make_ks();
    for (int n = 0; n < 32; n++) enc_mem[0][n] = pt[n] ^ ks[n];
    load_mem(0);
    run(0, 900, cyc);
    check("t4_cycles", cyc, 737);
    check("t4_key_valid", key_valid[0], 1);
    bad = 0;
    for (int n = 0; n < 32; n++) if (dec_mem[0][n] !== pt[n]) bad++;
    check("t4_plaintext_errors", bad, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("t4_done_held", done[0], 1);
    stop(0);
    check("t4_done_drop", done[0], 0);
    check("t4_key_valid_drop", key_valid[0], 0);

    // Asynchronous reset in the middle of WR_J, then a clean re-run.
    load_mem(0);
    @(negedge clk); start[0] = 1'b1;
    repeat (14) @(posedge clk);
    #2;
    check("t5_in_wr_j", s_wren[0], 1);
    rst[0] = 1'b1;
    #1;
    check("t5_s_wren", s_wren[0], 0);
    check("t5_dec_wren", dec_wren[0], 0);
    check("t5_done", done[0], 0);
    check("t5_s_address", s_address[0], 0);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (s_wren[0] || dec_wren[0]) seen++; end
    check("t5_writes_in_reset", seen, 0);
    start[0] = 1'b0;
    @(negedge clk); rst[0] = 1'b0;
    load_mem(0);
    run(0, 900, cyc);
    check("t5_cycles", cyc, 737);
    check("t5_key_valid", key_valid[0], 1);
    bad = 0;
    for (int n = 0; n < 32; n++) if (dec_mem[0][n] !== pt[n]) bad++;
    check("t5_plaintext_errors", bad, 0);
    stop(0);

    // start dropped while in RD_F.
    load_mem(0);
    @(negedge clk); start[0] = 1'b1;
    repeat (16) @(posedge clk);
    #2;
    start[0] = 1'b0;
    @(posedge clk); #1;
    check("t6_s_wren", s_wren[0], 0);
    check("t6_dec_wren", dec_wren[0], 0);
    check("t6_done", done[0], 0);
    check("t6_s_address", s_address[0], 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done[0] || dec_wren[0] || s_wren[0]) seen++; end
    check("t6_activity_after_abort", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
